sumador_sched: RTL

Round-robin scheduler that shares one pipelined 4-bit adder (sumador) between two requesters.
- Accepts operand pairs over valid/ready.
- Drives the adder's dataA/dataB with a 4-bit idx tag.
- Decodes the tag that returns on idx_dd alongside sum30_dd and routes each sum back to its requester.
- Supports a drain command that quiesces the adder before it is reconfigured or reset.

---
 rtl/sumador_pkg.sv | 30 +++
 rtl/sumador_rr_arb.sv | 53 +++++
 rtl/sumador_sched.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sumador_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sumador_pkg
//  Description : Shared definitions for the sumador scheduler: state codes,
//                adder tag field positions and datapath defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package sumador_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int LAT_DEF    = 2;
  localparam int MAXFLY_DEF = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Tag layout on idx / idx_dd
  localparam int IDX_V      = 3;
  localparam int IDX_ID     = 2;
  localparam int IDX_SEQ_HI = 1;
  localparam int IDX_SEQ_LO = 0;

  // Build a live tag for requester id carrying sequence number seq
  function automatic logic [3:0] make_idx(input logic id, input logic [1:0] seq);
    return {1'b1, id, seq};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sumador_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : sumador_rr_arb
//  Description : Two-way round-robin arbiter. When both requesters are valid
//                the one not granted last wins; the pointer only moves when
//                a grant is actually issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module sumador_rr_arb
  import sumador_pkg::*;
(
  input  logic       clk,
  input  logic       reset_L,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  // prio_q holds the requester id that wins a tie
  logic prio_q;
  logic prio_d;

  // Grant at most one valid requester while enabled
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) begin
        grant = prio_q ? 2'b10 : 2'b01;
      end else begin
        grant = valid;
      end
    end
  end

  // After a grant, the other requester becomes preferred
  always_comb begin
    prio_d = prio_q;
    if (grant != 2'b00) begin
      prio_d = ~grant[1];
    end
  end

  // Pointer register; requester 0 preferred out of reset
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sumador_sched.sv
`default_nettype none
// ============================================================================
//  Module      : sumador_sched
//  Description : Shares one pipelined adder between two requesters. Operand
//                pairs are tagged {valid, id, seq}, sent to the adder, and the
//                returning tag routes each sum back to its requester. A drain
//                level stops new issue and pulses drain_done once empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module sumador_sched
  import sumador_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int LAT    = LAT_DEF,
  parameter int MAXFLY = MAXFLY_DEF
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_dataA,
  input  logic [WIDTH-1:0] req0_dataB,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_dataA,
  input  logic [WIDTH-1:0] req1_dataB,
  output logic             req1_ready,
  input  logic             drain_req,
  output logic             drain_done,
  output logic [WIDTH-1:0] dataA,
  output logic [WIDTH-1:0] dataB,
  output logic [3:0]       idx,
  input  logic [WIDTH-1:0] sum30_dd,
  input  logic [3:0]       idx_dd,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_sum,
  output logic [1:0]       resp_seq
);

  localparam int CNT_W   = $clog2(MAXFLY + 1);
  localparam int FLUSH_W = $clog2(LAT + 1);
  localparam logic [CNT_W-1:0]   MAXFLY_C = CNT_W'(MAXFLY);
  localparam logic [FLUSH_W-1:0] LAT_C    = FLUSH_W'(LAT);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic [1:0]         seq0_q, seq0_d;
  logic [1:0]         seq1_q, seq1_d;
  logic [WIDTH-1:0]   data_a_q, data_a_d;
  logic [WIDTH-1:0]   data_b_q, data_b_d;
  logic [3:0]         idx_q, idx_d;
  logic               resp0_valid_q, resp0_valid_d;
  logic               resp1_valid_q, resp1_valid_d;
  logic [WIDTH-1:0]   resp_sum_q, resp_sum_d;
  logic [1:0]         resp_seq_q, resp_seq_d;
  logic               drain_done_q, drain_done_d;
  logic               drained_q, drained_d;

  logic       can_issue;
  logic [1:0] grant;
  logic       issue;
  logic       gid;
  logic [1:0] cur_seq;
  logic       ret;
  logic       dec;

  sumador_rr_arb u_arb (
    .clk     (clk),
    .reset_L (reset_L),
    .en      (can_issue),
    .valid   ({req1_valid, req0_valid}),
    .grant   (grant)
  );

  assign issue = |grant;
  assign gid   = grant[1];

  // FSM state register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; drained_q stops re-entering DRAIN while the same drain level is held
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_BUSY: begin
        if (drain_req && !drained_q) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = (inflight_d != '0) ? ST_BUSY : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (inflight_q == '0) begin
          state_d = ST_IDLE;
        end else if (!drain_req) begin
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: issue enable and the drain-complete pulse
  always_comb begin
    can_issue    = reset_L && !drain_req && (inflight_q < MAXFLY_C) &&
                   ((state_q == ST_IDLE) || (state_q == ST_BUSY));
    drain_done_d = (state_q == ST_DRAIN) && (inflight_q == '0);
    drained_d    = drain_req && (drained_q || drain_done_d);
  end

  // Datapath: issue registers, sequence counters, in-flight count and return routing.
  // For LAT cycles after reset the returning tags belong to discarded work, so they are ignored.
  always_comb begin
    ret = idx_dd[IDX_V] && (flush_q == '0);
    dec = ret && (inflight_q != '0);

    inflight_d = inflight_q;
    if (issue && !dec) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!issue && dec) begin
      inflight_d = inflight_q - CNT_W'(1);
    end

    flush_d = (flush_q != '0) ? (flush_q - FLUSH_W'(1)) : flush_q;

    cur_seq = gid ? seq1_q : seq0_q;
    seq0_d  = seq0_q;
    seq1_d  = seq1_q;
    if (issue && !gid) seq0_d = seq0_q + 2'd1;
    if (issue &&  gid) seq1_d = seq1_q + 2'd1;

    data_a_d = data_a_q;
    data_b_d = data_b_q;
    idx_d    = 4'b0000;
    if (issue) begin
      data_a_d = gid ? req1_dataA : req0_dataA;
      data_b_d = gid ? req1_dataB : req0_dataB;
      idx_d    = make_idx(gid, cur_seq);
    end

    resp0_valid_d = ret && !idx_dd[IDX_ID];
    resp1_valid_d = ret &&  idx_dd[IDX_ID];
    resp_sum_d    = ret ? sum30_dd : resp_sum_q;
    resp_seq_d    = ret ? idx_dd[IDX_SEQ_HI:IDX_SEQ_LO] : resp_seq_q;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      inflight_q    <= '0;
      flush_q       <= LAT_C;
      seq0_q        <= 2'd0;
      seq1_q        <= 2'd0;
      data_a_q      <= '0;
      data_b_q      <= '0;
      idx_q         <= 4'b0000;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp_sum_q    <= '0;
      resp_seq_q    <= 2'd0;
      drain_done_q  <= 1'b0;
      drained_q     <= 1'b0;
    end else begin
      inflight_q    <= inflight_d;
      flush_q       <= flush_d;
      seq0_q        <= seq0_d;
      seq1_q        <= seq1_d;
      data_a_q      <= data_a_d;
      data_b_q      <= data_b_d;
      idx_q         <= idx_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp_sum_q    <= resp_sum_d;
      resp_seq_q    <= resp_seq_d;
      drain_done_q  <= drain_done_d;
      drained_q     <= drained_d;
    end
  end

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign dataA       = data_a_q;
  assign dataB       = data_b_q;
  assign idx         = idx_q;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp_sum    = resp_sum_q;
  assign resp_seq    = resp_seq_q;
  assign drain_done  = drain_done_q;

endmodule
`default_nettype wire
